// File: rtl/alu_iterative.sv
// Iterative ALU: logical/arithmetic/compare ops finish in one cycle, shifts move one bit per cycle.
// Handshake: a transfer happens on a rising edge where valid && ready; the sender holds valid and payload until that edge.
module alu_iterative #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       alucontrol,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic [1:0]       dbg_state
);
    localparam int SHW = $clog2(WIDTH);

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLL = 3'b011;
    localparam logic [2:0] OP_SRL = 3'b100;
    localparam logic [2:0] OP_SRA = 3'b101;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLT = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [SHW-1:0]   cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             zero_q, zero_d;

    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] acc_step;
    logic [SHW-1:0]   shamt;
    logic             is_shift;
    logic             accept;

    assign shamt    = b[SHW-1:0];
    assign is_shift = (alucontrol == OP_SLL) || (alucontrol == OP_SRL) || (alucontrol == OP_SRA);

    // Shift codes fall to the default: a zero-amount shift simply returns a.
    always_comb begin
        alu_res = a;
        case (alucontrol)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_AND:  alu_res = a & b;
            OP_OR:   alu_res = a | b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default: alu_res = a;
        endcase
    end

    always_comb begin
        acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        case (op_q)
            OP_SLL:  acc_step = acc_q << 1;
            OP_SRL:  acc_step = acc_q >> 1;
            default: acc_step = {acc_q[WIDTH-1], acc_q[WIDTH-1:1]};
        endcase
    end

    assign in_ready  = (state_q == ST_IDLE) || ((state_q == ST_DONE) && out_ready);
    assign out_valid = (state_q == ST_DONE);
    assign accept    = in_valid && in_ready;
    assign result    = result_q;
    assign zero      = zero_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        result_d = result_q;
        zero_d   = zero_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && out_ready) begin
                    state_d = ST_IDLE;
                end
                if (accept) begin
                    if (!is_shift || shamt == '0) begin
                        result_d = alu_res;
                        zero_d   = (alu_res == '0);
                        state_d  = ST_DONE;
                    end else begin
                        acc_d   = a;
                        cnt_d   = shamt;
                        op_d    = alucontrol;
                        state_d = ST_SHIFT;
                    end
                end
            end
            ST_SHIFT: begin
                acc_d = acc_step;
                cnt_d = cnt_q - SHW'(1);
                if (cnt_q == SHW'(1)) begin
                    result_d = acc_step;
                    zero_d   = (acc_step == '0);
                    state_d  = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            cnt_q    <= '0;
            op_q     <= '0;
            result_q <= '0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            result_q <= result_d;
            zero_q   <= zero_d;
        end
    end
endmodule

// File: tb/tb_alu_iterative.sv
// Bench for alu_iterative: directed literal cases plus random traffic checked every cycle
// against a transaction-level model (whole-word shifts, accept-cycle + latency timing).
module tb_alu_iterative;
    localparam int W = 32;

    localparam logic [2:0] C_AND = 3'b000;
    localparam logic [2:0] C_OR  = 3'b001;
    localparam logic [2:0] C_ADD = 3'b010;
    localparam logic [2:0] C_SLL = 3'b011;
    localparam logic [2:0] C_SRL = 3'b100;
    localparam logic [2:0] C_SRA = 3'b101;
    localparam logic [2:0] C_SUB = 3'b110;
    localparam logic [2:0] C_SLT = 3'b111;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [2:0]   alucontrol = '0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] result;
    logic         zero;
    logic [1:0]   dbg_state;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int acc_cyc = 0;
    bit chk_en = 1'b0;

    logic [W-1:0] exp_q[$];
    int           rdy_q[$];

    alu_iterative #(.WIDTH(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alucontrol (alucontrol),
        .a          (a),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .zero       (zero),
        .dbg_state  (dbg_state)
    );

    // clock / cycle counter
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [W-1:0] act, logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    function automatic logic [W-1:0] model_res(logic [2:0] ctl, logic [W-1:0] x, logic [W-1:0] y);
        int sh;
        sh = int'(y[4:0]);
        case (ctl)
            C_ADD:   return x + y;
            C_SUB:   return x - y;
            C_AND:   return x & y;
            C_OR:    return x | y;
            C_SLT:   return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            C_SLL:   return x << sh;
            C_SRL:   return x >> sh;
            default: return W'($signed(x) >>> sh);
        endcase
    endfunction

    function automatic int model_lat(logic [2:0] ctl, logic [W-1:0] y);
        if (ctl == C_SLL || ctl == C_SRL || ctl == C_SRA) return int'(y[4:0]) + 1;
        return 1;
    endfunction

    // scoreboard: check outputs against the model, then advance the model for the coming edge
    always @(negedge clk) begin
        logic exp_ov;
        logic exp_ir;
        if (chk_en) begin
            exp_ov = 1'b0;
            if (exp_q.size() != 0) exp_ov = (cyc >= rdy_q[0]);
            exp_ir = (exp_q.size() == 0) || (exp_ov && out_ready);
            check("sb_out_valid", W'(out_valid), W'(exp_ov));
            check("sb_in_ready", W'(in_ready), W'(exp_ir));
            if (exp_ov) begin
                check("sb_result", result, exp_q[0]);
                check("sb_zero", W'(zero), W'(exp_q[0] == '0));
            end
            if (reset) begin
                exp_q.delete();
                rdy_q.delete();
            end else begin
                if (exp_ov && out_ready) begin
                    void'(exp_q.pop_front());
                    void'(rdy_q.pop_front());
                end
                if (in_valid && exp_ir) begin
                    exp_q.push_back(model_res(alucontrol, a, b));
                    rdy_q.push_back(cyc + model_lat(alucontrol, b));
                end
            end
        end
    end

    // driver: call at posedge+1, returns at posedge+1 after the accept edge
    task automatic send(input logic [2:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv, input bit rnd);
        int n;
        n = 0;
        in_valid = 1'b1;
        alucontrol = ctl;
        a = av;
        b = bv;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                total++;
                bad++;
                $display("FAIL send_timeout: got in_ready=0 expected 1 within 200 cycles");
                break;
            end
            @(posedge clk);
            #1;
            if (rnd) out_ready = 1'($urandom_range(0, 1));
        end
        acc_cyc = cyc;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = $urandom;
        b = $urandom;
        alucontrol = 3'($urandom_range(0, 7));
    endtask

    // waits for out_valid, checks literal result/zero/latency, returns at negedge
    task automatic wait_out(input string name, input logic [W-1:0] exp_res, input logic exp_z, input int exp_lat);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 100) begin
                total++;
                bad++;
                $display("FAIL %s_timeout: got out_valid=0 expected 1 within 100 cycles", name);
                return;
            end
        end
        check({name, "_res"}, result, exp_res);
        check({name, "_zero"}, W'(zero), W'(exp_z));
        check({name, "_lat"}, W'(cyc - acc_cyc), W'(exp_lat));
    endtask

    task automatic realign();
        @(posedge clk);
        #1;
    endtask

    task automatic op(input string name, input logic [2:0] ctl, input logic [W-1:0] av, input logic [W-1:0] bv,
                      input logic [W-1:0] exp_res, input logic exp_z, input int exp_lat);
        send(ctl, av, bv, 1'b0);
        wait_out(name, exp_res, exp_z, exp_lat);
        realign();
    endtask

    initial begin
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_en = 1'b1;
        check("rst_out_valid", W'(out_valid), '0);
        check("rst_result", result, '0);
        check("rst_zero", W'(zero), '0);
        check("rst_in_ready", W'(in_ready), W'(1));
        check("rst_state", W'(dbg_state), '0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        realign();

        // single-cycle ops
        op("add", C_ADD, 32'd5, 32'd7, 32'd12, 1'b0, 1);
        op("sub", C_SUB, 32'd7, 32'd7, 32'd0, 1'b1, 1);
        op("slt_neg", C_SLT, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1);
        op("slt_pos", C_SLT, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b1, 1);
        op("and", C_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000, 1'b0, 1);
        op("or", C_OR, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_FFF0, 1'b0, 1);
        op("sub_wrap", C_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0, 1);

        // shifts
        op("sra", C_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0, 5);
        op("srl", C_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0, 5);
        op("sll31", C_SLL, 32'd1, 32'd31, 32'h8000_0000, 1'b0, 32);
        op("sll0", C_SLL, 32'h1234_5678, 32'h20, 32'h1234_5678, 1'b0, 1);
        op("srl_out", C_SRL, 32'd1, 32'd1, 32'd0, 1'b1, 2);

        // backpressure then same-edge retire + accept
        out_ready = 1'b0;
        send(C_ADD, 32'd3, 32'd4, 1'b0);
        wait_out("bp", 32'd7, 1'b0, 1);
        for (int i = 0; i < 6; i++) begin
            realign();
            @(negedge clk);
            check("bp_hold_res", result, 32'd7);
            check("bp_hold_valid", W'(out_valid), W'(1));
            check("bp_hold_rdy", W'(in_ready), '0);
        end
        realign();
        out_ready = 1'b1;
        in_valid = 1'b1;
        alucontrol = C_ADD;
        a = 32'd1;
        b = 32'd1;
        @(negedge clk);
        check("bp_retire_rdy", W'(in_ready), W'(1));
        realign();
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", W'(out_valid), W'(1));
        check("bp_next_res", result, 32'd2);
        realign();

        // back-to-back stream
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            alucontrol = C_ADD;
            a = W'(10 * i);
            b = W'(i + 1);
            @(negedge clk);
            check("stream_rdy", W'(in_ready), W'(1));
            if (i > 0) begin
                check("stream_valid", W'(out_valid), W'(1));
                check("stream_res", result, W'(11 * (i - 1) + 1));
            end
            realign();
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_last", result, 32'd34);
        realign();

        // reset in the middle of a shift
        send(C_SLL, 32'd3, 32'd10, 1'b0);
        realign();
        realign();
        reset = 1'b1;
        realign();
        reset = 1'b0;
        @(negedge clk);
        check("midrst_valid", W'(out_valid), '0);
        check("midrst_res", result, '0);
        check("midrst_rdy", W'(in_ready), W'(1));
        check("midrst_state", W'(dbg_state), '0);
        realign();
        op("post_rst_add", C_ADD, 32'd20, 32'd22, 32'd42, 1'b0, 1);

        // random traffic with random backpressure
        for (int k = 0; k < 200; k++) begin
            logic [2:0]   rc;
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            rc = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) rb = ra;
            if ($urandom_range(0, 3) == 0) ra = 32'h8000_0000 | ra;
            send(rc, ra, rb, 1'b1);
            repeat ($urandom_range(0, 2)) begin
                out_ready = 1'($urandom_range(0, 1));
                realign();
            end
        end
        out_ready = 1'b1;
        for (int n = 0; n < 100 && exp_q.size() != 0; n++) realign();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        realign();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
